decode_dispatch_scheduler: RTL

In-order dispatch scheduler between the stage-2 decode mux and the functional units. It buffers decoded instructions in a small circular queue and steers the head entry to the unit selected by its 3-bit functional-unit code. It back-pressures decode when full and discards all in-flight work on a pipeline flush.

---
 rtl/decode_pkg.sv | 30 +++
 rtl/dispatch_fifo.sv | 49 ++++
 rtl/decode_dispatch_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction-format indices, functional-unit codes
// and the format-index width used by the decode/dispatch path.
package decode_pkg;

    localparam int unsigned formatIndexRange = 5;

    localparam logic [formatIndexRange-1:0] FMT_INVALID = 5'd0;
    localparam logic [formatIndexRange-1:0] FMT_D       = 5'd3;
    localparam logic [formatIndexRange-1:0] FMT_DQ      = 5'd4;
    localparam logic [formatIndexRange-1:0] FMT_DS      = 5'd5;
    localparam logic [formatIndexRange-1:0] FMT_MD      = 5'd9;
    localparam logic [formatIndexRange-1:0] FMT_X       = 5'd15;
    localparam logic [formatIndexRange-1:0] FMT_XO      = 5'd19;

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_MUL    = 3'd1,
        FU_DIV    = 3'd2,
        FU_LSU    = 3'd3,
        FU_BRANCH = 3'd4,
        FU_FPU    = 3'd5,
        FU_RSVD6  = 3'd6,
        FU_RSVD7  = 3'd7
    } fu_code_e;

    function automatic logic [7:0] fu_onehot(input logic [2:0] code);
        return 8'b1 << code;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Circular buffer with count-based full/empty; flush clears pointers and count.
module dispatch_fifo #(
    parameter int Depth = 4,
    parameter int Width = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [Width-1:0]       wdata,
    output logic [Width-1:0]       rdata,
    output logic [$clog2(Depth):0] count
);

    localparam int PW = $clog2(Depth);

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[tail] <= wdata;
    end

    assign rdata = mem[head];

endmodule

// File: rtl/decode_dispatch_scheduler.sv
// In-order dispatch scheduler: queues decoded instructions and steers the head
// to its functional unit. Optional same-cycle bypass: DISPATCH_BYPASS_EN.
module decode_dispatch_scheduler #(
    parameter int QueueDepth       = 4,
    parameter int NumUnits         = 6,
    parameter int PayloadWidth     = 128,
    parameter int addressSize      = 64,
    parameter int formatIndexRange = int'(decode_pkg::formatIndexRange)
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        flush_i,
    input  logic                        enable_i,
    input  logic [2:0]                  functionalUnitCode_i,
    input  logic [formatIndexRange-1:0] instructionFormat_i,
    input  logic [addressSize-1:0]      instructionAddress_i,
    input  logic [PayloadWidth-1:0]     payload_i,
    input  logic [NumUnits-1:0]         fuReady_i,
    output logic [NumUnits-1:0]         fuValid_o,
    output logic [formatIndexRange-1:0] instructionFormat_o,
    output logic [addressSize-1:0]      instructionAddress_o,
    output logic [PayloadWidth-1:0]     payload_o,
    output logic                        stall_o,
    output logic                        illegal_o,
    output logic                        overflow_o,
    output logic [$clog2(QueueDepth):0] occupancy_o
);

    import decode_pkg::*;

    localparam int CW = $clog2(QueueDepth) + 1;
    localparam int EW = 3 + formatIndexRange + addressSize + PayloadWidth;

    logic [CW-1:0]               count;
    logic [EW-1:0]               in_entry;
    logic [EW-1:0]               head_entry;
    logic [2:0]                  head_code;
    logic [formatIndexRange-1:0] head_fmt;
    logic [addressSize-1:0]      head_addr;
    logic [PayloadWidth-1:0]     head_payload;
    logic [7:0]                  ready_ext;
    logic [7:0]                  valid_ext;
    logic                        head_valid;
    logic                        head_legal;
    logic                        full;
    logic                        attempt;
    logic                        bypass;
    logic                        push;
    logic                        pop;
    logic                        illegal_q;
    logic                        overflow_q;

    assign in_entry = {functionalUnitCode_i, instructionFormat_i, instructionAddress_i, payload_i};
    assign {head_code, head_fmt, head_addr, head_payload} = head_entry;
    assign ready_ext  = 8'(fuReady_i);
    assign head_legal = {29'b0, head_code} < 32'(NumUnits);

    always_comb begin
        head_valid = (count != '0) && !flush_i;
        full       = (count == CW'(QueueDepth));
        attempt    = enable_i && !flush_i;
        // Illegal heads retire without waiting on any unit.
        pop        = head_valid && (!head_legal || ready_ext[head_code]);
`ifdef DISPATCH_BYPASS_EN
        bypass     = attempt && (count == '0)
                     && ({29'b0, functionalUnitCode_i} < 32'(NumUnits))
                     && ready_ext[functionalUnitCode_i];
`else
        bypass     = 1'b0;
`endif
        push       = attempt && !bypass && (!full || pop);

        valid_ext = '0;
        if (bypass)                        valid_ext = fu_onehot(functionalUnitCode_i);
        else if (head_valid && head_legal) valid_ext = fu_onehot(head_code);

        instructionFormat_o  = bypass ? instructionFormat_i  : head_fmt;
        instructionAddress_o = bypass ? instructionAddress_i : head_addr;
        payload_o            = bypass ? payload_i            : head_payload;
    end

    assign fuValid_o   = valid_ext[NumUnits-1:0];
    assign stall_o     = full;
    assign occupancy_o = count;
    assign illegal_o   = illegal_q;
    assign overflow_o  = overflow_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            illegal_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            illegal_q  <= head_valid && !head_legal;
            overflow_q <= overflow_q | (attempt && full && !pop);
        end
    end

    dispatch_fifo #(
        .Depth (QueueDepth),
        .Width (EW)
    ) u_fifo (
        .clock (clock_i),
        .reset (reset_i),
        .flush (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head_entry),
        .count (count)
    );

endmodule
